mem_stage: RTL and testbench

Memory-access pipeline stage between the execute stage and the write-back stage. It holds one instruction per cycle and waits for the data-SRAM response of loads and stores. It aligns and extends load data, then drives the `ms_to_ws` valid/allowin handshake and bus that the write-back stage consumes. It also sends forwarding and load-interlock information back to the decode stage.

---
 rtl/mem_stage.sv | 120 ++++++++++++
 tb/tb_mem_stage.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory-access stage: holds one EX instruction, waits for its data-SRAM response, aligns load data for WB.
// Latency: one cycle for non-memory ops or for data_ok on the first valid cycle; otherwise until data_ok.
// Backpressure: ms_allowin drops while waiting for data_ok or while WB withholds ws_allowin; early data is buffered.
module mem_stage (
  input  logic        clk,
  input  logic        resetn,
  input  logic        es_to_ms_valid,
  input  logic [75:0] es_to_ms_bus,
  output logic        ms_allowin,
  input  logic        data_sram_data_ok,
  input  logic [31:0] data_sram_rdata,
  input  logic        ws_allowin,
  output logic        ms_to_ws_valid,
  output logic [69:0] ms_to_ws_bus,
  output logic [38:0] ms_to_ds_bus
);

  typedef struct packed {
    logic [2:0]  ld_type;
    logic [1:0]  addr_low;
    logic        mem_req;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] pc;
  } es_bus_t;

  localparam logic [2:0] LD_LB  = 3'b001;
  localparam logic [2:0] LD_LBU = 3'b010;
  localparam logic [2:0] LD_LH  = 3'b011;
  localparam logic [2:0] LD_LHU = 3'b100;
  localparam logic [2:0] LD_LW  = 3'b101;

  logic        ms_valid_q, ms_valid_d;
  es_bus_t     bus_q, bus_d;
  logic        got_data_q, got_data_d;
  logic [31:0] rdata_buf_q, rdata_buf_d;

  logic        ms_ready_go;
  logic        ms_leave;
  logic        ld_is_none;
  logic [31:0] raw_word;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] final_result;

  // Handshake: a memory op may go only once its response is in hand (buffered or arriving now).
  always_comb begin
    ms_ready_go    = !bus_q.mem_req || got_data_q || data_sram_data_ok;
    ms_allowin     = !ms_valid_q || (ms_ready_go && ws_allowin);
    ms_to_ws_valid = ms_valid_q && ms_ready_go;
    ms_leave       = ms_valid_q && ms_ready_go && ws_allowin;
  end

  // Next-state: accept from EX, and capture a response that cannot be forwarded this cycle.
  always_comb begin
    ms_valid_d  = ms_valid_q;
    bus_d       = bus_q;
    got_data_d  = got_data_q;
    rdata_buf_d = rdata_buf_q;
    if (data_sram_data_ok && ms_valid_q && bus_q.mem_req && !got_data_q && !ms_leave) begin
      got_data_d  = 1'b1;
      rdata_buf_d = data_sram_rdata;
    end
    if (ms_allowin) begin
      ms_valid_d = es_to_ms_valid;
    end
    // A newly accepted instruction starts with no response; this overrides any capture above.
    if (es_to_ms_valid && ms_allowin) begin
      bus_d      = es_bus_t'(es_to_ms_bus);
      got_data_d = 1'b0;
    end
  end

  // State registers, cleared asynchronously so a mid-transaction reset drops the instruction at once.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ms_valid_q  <= 1'b0;
      bus_q       <= '0;
      got_data_q  <= 1'b0;
      rdata_buf_q <= '0;
    end else begin
      ms_valid_q  <= ms_valid_d;
      bus_q       <= bus_d;
      got_data_q  <= got_data_d;
      rdata_buf_q <= rdata_buf_d;
    end
  end

  // Load alignment and extension; live data_ok data wins over the buffered copy.
  always_comb begin
    raw_word   = data_sram_data_ok ? data_sram_rdata : rdata_buf_q;
    ld_is_none = !(bus_q.ld_type inside {LD_LB, LD_LBU, LD_LH, LD_LHU, LD_LW});
    case (bus_q.addr_low)
      2'b00:   sel_byte = raw_word[7:0];
      2'b01:   sel_byte = raw_word[15:8];
      2'b10:   sel_byte = raw_word[23:16];
      default: sel_byte = raw_word[31:24];
    endcase
    sel_half = bus_q.addr_low[1] ? raw_word[31:16] : raw_word[15:0];
    case (bus_q.ld_type)
      LD_LB:   final_result = {{24{sel_byte[7]}}, sel_byte};
      LD_LBU:  final_result = {24'd0, sel_byte};
      LD_LH:   final_result = {{16{sel_half[15]}}, sel_half};
      LD_LHU:  final_result = {16'd0, sel_half};
      LD_LW:   final_result = raw_word;
      default: final_result = bus_q.alu_result;
    endcase
  end

  // Output buses carry register contents regardless of validity; only the enable bits are gated.
  always_comb begin
    ms_to_ws_bus = {bus_q.gr_we, bus_q.dest, final_result, bus_q.pc};
    ms_to_ds_bus = {ms_valid_q && bus_q.mem_req && !ld_is_none && !got_data_q && !data_sram_data_ok,
                    ms_valid_q && bus_q.gr_we,
                    bus_q.dest,
                    final_result};
  end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

  logic        clk;
  logic        resetn;
  logic        es_to_ms_valid;
  logic [75:0] es_to_ms_bus;
  logic        ms_allowin;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        ws_allowin;
  logic        ms_to_ws_valid;
  logic [69:0] ms_to_ws_bus;
  logic [38:0] ms_to_ds_bus;

  int checks;
  int failures;

  mem_stage dut (
    .clk               (clk),
    .resetn            (resetn),
    .es_to_ms_valid    (es_to_ms_valid),
    .es_to_ms_bus      (es_to_ms_bus),
    .ms_allowin        (ms_allowin),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .ws_allowin        (ws_allowin),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ms_to_ws_bus      (ms_to_ws_bus),
    .ms_to_ds_bus      (ms_to_ds_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [75:0] mk_bus(input logic [2:0] ld, input logic [1:0] al, input logic mreq,
                                         input logic we, input logic [4:0] dest, input logic [31:0] alu,
                                         input logic [31:0] pc);
    return {ld, al, mreq, we, dest, alu, pc};
  endfunction

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (ms_allowin !== 1'b1) begin failures++; $display("FAIL reset_allowin got=%b exp=1", ms_allowin); end
    checks++;
    if (ms_to_ws_valid !== 1'b0) begin failures++; $display("FAIL reset_ws_valid got=%b exp=0", ms_to_ws_valid); end
    checks++;
    if (ms_to_ws_bus !== 70'd0) begin failures++; $display("FAIL reset_ws_bus got=%h exp=0", ms_to_ws_bus); end
    checks++;
    if (ms_to_ds_bus !== 39'd0) begin failures++; $display("FAIL reset_ds_bus got=%h exp=0", ms_to_ds_bus); end
    step();
    resetn = 1'b1;
  endtask

  task automatic test_alu();
    step();
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk_bus(3'b000, 2'b00, 1'b0, 1'b1, 5'd5, 32'h0000_1234, 32'h0000_0100);
    ws_allowin     = 1'b1;
    #1;
    checks++;
    if (ms_allowin !== 1'b1) begin failures++; $display("FAIL alu_accept got=%b exp=1", ms_allowin); end
    step();
    es_to_ms_valid = 1'b0;
    #1;
    checks++;
    if (ms_to_ws_valid !== 1'b1) begin failures++; $display("FAIL alu_ws_valid got=%b exp=1", ms_to_ws_valid); end
    checks++;
    if (ms_to_ws_bus !== {1'b1, 5'd5, 32'h0000_1234, 32'h0000_0100})
      begin failures++; $display("FAIL alu_ws_bus got=%h exp=%h", ms_to_ws_bus, {1'b1, 5'd5, 32'h0000_1234, 32'h0000_0100}); end
    checks++;
    if (ms_to_ds_bus !== {1'b0, 1'b1, 5'd5, 32'h0000_1234})
      begin failures++; $display("FAIL alu_ds_bus got=%h exp=%h", ms_to_ds_bus, {1'b0, 1'b1, 5'd5, 32'h0000_1234}); end
    step();
    #1;
    checks++;
    if (ms_to_ws_valid !== 1'b0) begin failures++; $display("FAIL alu_drain got=%b exp=0", ms_to_ws_valid); end
  endtask

  task automatic test_lb_late();
    step();
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk_bus(3'b001, 2'b11, 1'b1, 1'b1, 5'd7, 32'h0000_2003, 32'h0000_0200);
    step();
    es_to_ms_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) step();
      #1;
      checks++;
      if ({ms_to_ds_bus[38], ms_to_ws_valid, ms_allowin} !== 3'b100)
        begin failures++; $display("FAIL lb_wait[%0d] pend/vld/allowin got=%b exp=100", i, {ms_to_ds_bus[38], ms_to_ws_valid, ms_allowin}); end
    end
    step();
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h80FF_0000;
    #1;
    checks++;
    if (ms_to_ws_valid !== 1'b1) begin failures++; $display("FAIL lb_ws_valid got=%b exp=1", ms_to_ws_valid); end
    checks++;
    if (ms_to_ws_bus[63:32] !== 32'hFFFF_FF80) begin failures++; $display("FAIL lb_result got=%h exp=ffffff80", ms_to_ws_bus[63:32]); end
    step();
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'h0;
    #1;
    checks++;
    if (ms_to_ws_valid !== 1'b0) begin failures++; $display("FAIL lb_drain got=%b exp=0", ms_to_ws_valid); end
  endtask

  task automatic test_lhu_stall();
    step();
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk_bus(3'b100, 2'b10, 1'b1, 1'b1, 5'd9, 32'h0000_3002, 32'h0000_0300);
    ws_allowin     = 1'b0;
    step();
    es_to_ms_valid    = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h8001_7F7F;
    #1;
    checks++;
    if ({ms_to_ws_valid, ms_allowin} !== 2'b10) begin failures++; $display("FAIL lhu_dok vld/allowin got=%b exp=10", {ms_to_ws_valid, ms_allowin}); end
    checks++;
    if (ms_to_ws_bus[63:32] !== 32'h0000_8001) begin failures++; $display("FAIL lhu_dok_result got=%h exp=00008001", ms_to_ws_bus[63:32]); end
    for (int i = 0; i < 2; i++) begin
      step();
      data_sram_data_ok = 1'b0;
      data_sram_rdata   = 32'hDEAD_BEEF;
      #1;
      checks++;
      if ({ms_to_ws_valid, ms_allowin} !== 2'b10)
        begin failures++; $display("FAIL lhu_hold[%0d] vld/allowin got=%b exp=10", i, {ms_to_ws_valid, ms_allowin}); end
      checks++;
      if (ms_to_ws_bus !== {1'b1, 5'd9, 32'h0000_8001, 32'h0000_0300})
        begin failures++; $display("FAIL lhu_hold_bus[%0d] got=%h", i, ms_to_ws_bus); end
    end
    step();
    ws_allowin = 1'b1;
    #1;
    checks++;
    if ({ms_to_ws_valid, ms_allowin} !== 2'b11) begin failures++; $display("FAIL lhu_release vld/allowin got=%b exp=11", {ms_to_ws_valid, ms_allowin}); end
    step();
    #1;
    checks++;
    if (ms_to_ws_valid !== 1'b0) begin failures++; $display("FAIL lhu_drain got=%b exp=0", ms_to_ws_valid); end
  endtask

  task automatic test_store();
    step();
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk_bus(3'b000, 2'b00, 1'b1, 1'b0, 5'd3, 32'h0000_CAFE, 32'h0000_0400);
    step();
    es_to_ms_valid = 1'b0;
    #1;
    checks++;
    if ({ms_to_ds_bus[38], ms_to_ws_valid, ms_allowin} !== 3'b000)
      begin failures++; $display("FAIL store_wait pend/vld/allowin got=%b exp=000", {ms_to_ds_bus[38], ms_to_ws_valid, ms_allowin}); end
    step();
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h1111_2222;
    #1;
    checks++;
    if (ms_to_ws_valid !== 1'b1) begin failures++; $display("FAIL store_ws_valid got=%b exp=1", ms_to_ws_valid); end
    checks++;
    if (ms_to_ds_bus !== {1'b0, 1'b0, 5'd3, 32'h0000_CAFE})
      begin failures++; $display("FAIL store_ds_bus got=%h exp=%h", ms_to_ds_bus, {1'b0, 1'b0, 5'd3, 32'h0000_CAFE}); end
    step();
    data_sram_data_ok = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd [4];
    logic [31:0] pcs [4];
    for (int i = 0; i < 4; i++) begin
      rd[i]  = 32'hA000_0000 + 32'(i * 32'h0101);
      pcs[i] = 32'h0000_1000 + 32'(i * 4);
    end
    step();
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk_bus(3'b101, 2'b00, 1'b1, 1'b1, 5'd10, 32'h0, pcs[0]);
    for (int i = 0; i < 4; i++) begin
      step();
      if (i < 3) es_to_ms_bus = mk_bus(3'b101, 2'b00, 1'b1, 1'b1, 5'(11 + i), 32'h0, pcs[i+1]);
      else       es_to_ms_valid = 1'b0;
      data_sram_data_ok = 1'b1;
      data_sram_rdata   = rd[i];
      #1;
      checks++;
      if ({ms_to_ws_valid, ms_allowin} !== 2'b11)
        begin failures++; $display("FAIL b2b_vld[%0d] vld/allowin got=%b exp=11", i, {ms_to_ws_valid, ms_allowin}); end
      checks++;
      if (ms_to_ws_bus !== {1'b1, 5'(10 + i), rd[i], pcs[i]})
        begin failures++; $display("FAIL b2b_bus[%0d] got=%h exp=%h", i, ms_to_ws_bus, {1'b1, 5'(10 + i), rd[i], pcs[i]}); end
    end
    step();
    data_sram_data_ok = 1'b0;
    #1;
    checks++;
    if (ms_to_ws_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%b exp=0", ms_to_ws_valid); end
  endtask

  task automatic test_reset_mid_load();
    step();
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk_bus(3'b101, 2'b00, 1'b1, 1'b1, 5'd4, 32'h0000_5000, 32'h0000_0500);
    step();
    es_to_ms_valid = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    checks++;
    if ({ms_to_ws_valid, ms_allowin} !== 2'b01)
      begin failures++; $display("FAIL rst_mid vld/allowin got=%b exp=01", {ms_to_ws_valid, ms_allowin}); end
    checks++;
    if (ms_to_ds_bus !== 39'd0) begin failures++; $display("FAIL rst_mid_ds_bus got=%h exp=0", ms_to_ds_bus); end
    step();
    resetn = 1'b1;
    step();
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h1234_5678;
    step();
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'h0;
    #1;
    checks++;
    if ({ms_to_ws_valid, ms_allowin} !== 2'b01)
      begin failures++; $display("FAIL stray_dok vld/allowin got=%b exp=01", {ms_to_ws_valid, ms_allowin}); end
    checks++;
    if (ms_to_ws_bus !== 70'd0) begin failures++; $display("FAIL stray_dok_bus got=%h exp=0", ms_to_ws_bus); end
    // A fresh load must still wait: the stray response set no got_data.
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk_bus(3'b101, 2'b00, 1'b1, 1'b1, 5'd6, 32'h0, 32'h0000_0600);
    step();
    es_to_ms_valid = 1'b0;
    #1;
    checks++;
    if ({ms_to_ws_valid, ms_to_ds_bus[38]} !== 2'b01)
      begin failures++; $display("FAIL stray_next_wait vld/pend got=%b exp=01", {ms_to_ws_valid, ms_to_ds_bus[38]}); end
    step();
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h0BAD_F00D;
    step();
    data_sram_data_ok = 1'b0;
  endtask

  initial begin
    checks            = 0;
    failures          = 0;
    resetn            = 1'b0;
    es_to_ms_valid    = 1'b0;
    es_to_ms_bus      = '0;
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = '0;
    ws_allowin        = 1'b1;
    test_reset();
    test_alu();
    test_lb_late();
    test_lhu_stall();
    test_store();
    test_back_to_back();
    test_reset_mid_load();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
